// File: rtl/led_sequencer.sv
// led_sequencer: steps an 8-bit LED bank through BLINK/CHASE/BOUNCE/COUNT
// patterns at a CLK_DIV rate. Optional macro LED_SEQ_PWM_EN adds brightness PWM.
module led_sequencer #(
    parameter int CLK_DIV = 6000000,
    parameter int CNT_W   = 23
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] mode,
    input  logic       mode_valid,
    output logic       mode_ready,
    input  logic       run,
`ifdef LED_SEQ_PWM_EN
    input  logic [3:0] brightness,
`endif
    output logic       step_tick,
    output logic       busy,
    output logic [7:0] led
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_e;

    typedef enum logic [1:0] {
        M_BLINK,
        M_CHASE,
        M_BOUNCE,
        M_COUNT
    } mode_e;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_e           r_state;
    mode_e            r_mode;
    logic [7:0]       r_pat;
    logic             r_dir;
    logic [CNT_W-1:0] r_presc;
    logic             r_tick;

    logic       w_accept;
    logic [7:0] w_seed;
    logic [7:0] w_next_pat;
    logic       w_next_dir;

    assign busy       = (r_state == S_RUN);
    assign mode_ready = (r_state != S_RUN);
    assign step_tick  = r_tick;
    assign w_accept   = mode_valid && (r_state != S_RUN);

    // Seed pattern for a freshly loaded mode
    always_comb begin
        w_seed = 8'hAA;
        unique case (mode_e'(mode))
            M_BLINK:  w_seed = 8'hAA;
            M_CHASE:  w_seed = 8'h01;
            M_BOUNCE: w_seed = 8'h01;
            M_COUNT:  w_seed = 8'h00;
        endcase
    end

    // Next pattern and bounce direction for one step of the current mode
    always_comb begin
        w_next_pat = r_pat;
        w_next_dir = r_dir;
        unique case (r_mode)
            M_BLINK:  w_next_pat = ~r_pat;
            M_CHASE:  w_next_pat = {r_pat[6:0], r_pat[7]};
            M_BOUNCE: begin
                if (!r_dir) begin
                    w_next_pat = {r_pat[6:0], 1'b0};
                    if (w_next_pat == 8'h80) w_next_dir = 1'b1;
                end else begin
                    w_next_pat = {1'b0, r_pat[7:1]};
                    if (w_next_pat == 8'h01) w_next_dir = 1'b0;
                end
            end
            M_COUNT:  w_next_pat = r_pat + 8'd1;
        endcase
    end

    // Control FSM, prescaler and pattern register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_mode  <= M_BLINK;
            r_pat   <= 8'hAA;
            r_dir   <= 1'b0;
            r_presc <= RELOAD;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_accept) begin
                r_mode  <= mode_e'(mode);
                r_pat   <= w_seed;
                r_dir   <= 1'b0;
                r_presc <= RELOAD;
                r_state <= run ? S_RUN : S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (run) begin
                            r_state <= S_RUN;
                            r_presc <= RELOAD;
                        end
                    end
                    S_RUN: begin
                        if (r_presc == '0) begin
                            r_presc <= RELOAD;
                            r_tick  <= 1'b1;
                            r_pat   <= w_next_pat;
                            r_dir   <= w_next_dir;
                        end else if (run) begin
                            r_presc <= r_presc - ONE;
                        end
                        if (!run) r_state <= S_PAUSE;
                    end
                    S_PAUSE: begin
                        if (run) r_state <= S_RUN;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic [7:0] r_led;

    // Brightness gating of the pattern, one cycle behind the pattern register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pwm_cnt <= 4'd0;
            r_led     <= 8'hAA;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            r_led     <= r_pat & {8{r_pwm_cnt < brightness}};
        end
    end

    assign led = r_led;
`else
    assign led = r_pat;
`endif

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Controller that sequences the 8-bit LED bank through selectable display patterns at a programmable step rate. It replaces the fixed invert-on-terminal-count blinker with four modes, run/pause control and a valid/ready mode-load handshake. The block owns the prescaler and the pattern register. It drives the board LEDs directly from the top level.

Parameters:
CLK_DIV, 6000000, sys_clk cycles per pattern step; legal range 2 .. 2^CNT_W-1.
CNT_W, 23, prescaler counter width.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rst  input  1  synchronous, active-high reset.
mode  input  2  pattern select: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT.
mode_valid  input  1  mode load request.
mode_ready  output  1  high when a mode load can be accepted.
run  input  1  level; 1 = advance pattern, 0 = hold.
step_tick  output  1  one-cycle pulse on each pattern step.
busy  output  1  high while the block is in RUN.
led  output  8  registered LED drive.

Behaviour:
- Reset (sys_rst=1 at an edge) takes priority over everything, including mid-step:
  - state=IDLE, mode_reg=BLINK, led=8'hAA, dir=left.
  - prescaler=CLK_DIV-1, step_tick=0.
- States: IDLE, RUN, PAUSE. Outputs are combinational from state: busy = (state==RUN); mode_ready = (state!=RUN).
- Accept: occurs when mode_valid & mode_ready in the same cycle. On the next edge:
  - mode_reg=mode; led loaded with the seed: BLINK 8'hAA, CHASE 8'h01, BOUNCE 8'h01, COUNT 8'h00.
  - dir=left, prescaler=CLK_DIV-1.
  - Next state: RUN if run=1 that cycle, else IDLE.
  - mode_valid during RUN is ignored; no accept occurs.
- Transitions without an accept:
  - IDLE->RUN on run=1, prescaler reloaded to CLK_DIV-1.
  - RUN->PAUSE on run=0; prescaler and led are held.
  - PAUSE->RUN on run=1; the prescaler resumes from its held value and is not reloaded.
- Prescaler in RUN:
  - Decrements by 1 each cycle.
  - When it equals 0: reload CLK_DIV-1, pulse step_tick for exactly one cycle (registered, aligned with the led update), and apply the step.
  - Step period is exactly CLK_DIV cycles. The first step comes CLK_DIV cycles after the RUN-entry edge.
- Step rules:
  - BLINK: led = ~led.
  - CHASE: rotate left; 8'h80 -> 8'h01.
  - BOUNCE: shift in dir. On reaching 8'h80, dir becomes right; on reaching 8'h01, dir becomes left. Endpoints are shown once, giving the sequence 01,02,..,80,40,..,01,02.
  - COUNT: led = led + 1, modulo 256 (FF -> 00).
- Simultaneous events:
  - If run falls in the cycle where the prescaler is 0, the step and tick still occur that edge; the state becomes PAUSE with the prescaler at CLK_DIV-1.
  - In IDLE/PAUSE the prescaler does not count and step_tick stays 0.
- step_tick and led never change in IDLE or PAUSE except on an accept (led seeds) or reset.

Optional Feature:
- Macro: LED_SEQ_PWM_EN.
- When defined:
  - Adds input port brightness[3:0].
  - A free-running 4-bit pwm_cnt (reset 0, increments every cycle) gates the output: led = pattern_reg & {8{pwm_cnt < brightness}}, registered, so one extra cycle of latency from the pattern register.
  - brightness=0 gives LEDs always off; 15 gives 15/16 duty.
  - Pattern sequencing, step_tick and the handshake are unchanged.
- When undefined: no brightness port, no pwm_cnt, led = pattern register directly.

Test Plan (CLK_DIV=4):
1. Reset then hold run=0 for 20 cycles -> led=8'hAA, busy=0, mode_ready=1, step_tick never high.
2. Accept mode=CHASE with run=0, then raise run -> led=01, then 02 after 4 cycles, 04 4 cycles later; after 8 steps led=01 again (wrap). One step_tick per step, 1 cycle wide.
3. Accept BOUNCE, run 16 steps -> led sequence 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04.
4. Accept COUNT from seed 00, run 256 steps -> led=00 after wrap. Drop run for 10 cycles mid-count -> led held, busy=0. Raise run -> next step exactly at the remaining prescaler count.
5. Assert mode_valid with mode=BLINK during RUN -> mode_ready=0, pattern unaffected. Assert sys_rst mid-step -> next cycle led=AA, IDLE, step_tick=0.
6. With LED_SEQ_PWM_EN, brightness=4, pattern FF -> led=FF for exactly 4 of every 16 cycles. With brightness=0 -> led=00 constantly.
